wb_stage: RTL
=============

Name: wb_stage

Overview:
- Write-back stage sitting directly upstream of the register file.
- Accepts one completed instruction per handshake: either an ALU result or a load.
- For loads, waits for data-memory read data, then extracts and extends the byte/halfword/word (big-endian).
- Drives the register file write port (Write_Reg_Num, Write_Data, regwrite) as a registered one-cycle pulse; also exposes pending-result forwarding and error/retire status.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in WAIT_MEM before abort; 0 disables the timeout
CNT_W, 32, width of the retire counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
in_rd  input  5  destination register number
in_regwrite  input  1  instruction writes a register
in_memtoreg  input  1  1 = load (result from memory), 0 = ALU result
in_load_type  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU (others treated as LW)
in_alu_result  input  32  ALU result; for loads, the effective address (bits 1:0 select lane)
mem_rdata_valid  input  1  memory read data valid (single-cycle pulse)
mem_rdata  input  32  memory read word, big-endian lanes (addr 0 = bits 31:24)
Write_Reg_Num  output  5  register file write address
Write_Data  output  32  register file write data
regwrite  output  1  register file write enable, one-cycle pulse
fwd_valid  output  1  a write to fwd_rd is pending or being written this cycle
fwd_rd  output  5  destination register of the pending write
wb_err  output  2  one-cycle pulse: 01 misaligned load, 10 memory timeout
retire_count  output  CNT_W  count of accepted instructions that completed without error; wraps

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; timeout counter 0.
  - regwrite, Write_Reg_Num, Write_Data, fwd_valid, fwd_rd, wb_err and retire_count all 0.
  - in_ready=1 after reset deassertion.
- FSM states: IDLE, WAIT_MEM, WRITE.
- in_ready = (state==IDLE) || (state==WRITE). Transfer occurs when in_valid && in_ready.
- Transfer with in_memtoreg=0 → WRITE next cycle.
  - Write_Data = in_alu_result, Write_Reg_Num = in_rd.
  - regwrite = in_regwrite && (in_rd!=0).
  - Latency is 1 cycle from transfer to the regwrite pulse.
- Transfer with in_memtoreg=1:
  - Misaligned (LW with addr[1:0]!=0; LH/LHU with addr[0]=1) → wb_err=01 for one cycle, no write, no retire, next state IDLE.
  - Otherwise → WAIT_MEM; capture rd, regwrite, load type and addr[1:0]; clear the timeout counter.
- WAIT_MEM:
  - mem_rdata_valid=1 → WRITE next cycle with extracted data.
  - Else the counter increments. When it reaches MEM_TIMEOUT (if MEM_TIMEOUT≠0) → wb_err=10 for one cycle, no write, no retire, next state IDLE.
  - in_ready=0 in this state.
- Load extraction:
  - LB/LBU: byte at lane addr[1:0] (lane 0 = mem_rdata[31:24]); sign-extended for LB, zero-extended for LBU.
  - LH/LHU: lane addr[1] (0 = bits 31:16); sign-extended for LH, zero-extended for LHU.
  - LW: full word.
- WRITE:
  - regwrite is high for exactly this cycle (if enabled and rd≠0); retire_count increments by 1.
  - rd=0 or in_regwrite=0: no register write, but the instruction still retires.
  - A simultaneous new transfer is accepted (back-to-back, full throughput for ALU ops). Otherwise next state IDLE.
- Outputs are registered:
  - Write_Reg_Num and Write_Data hold their last values outside WRITE.
  - regwrite=0 outside WRITE.
- mem_rdata_valid outside WAIT_MEM is ignored.
- Forwarding:
  - fwd_valid=1 while in WAIT_MEM or WRITE with a captured regwrite && rd≠0.
  - fwd_rd = captured rd. fwd_rd holds its value when fwd_valid=0.
- Reset asserted mid-WAIT_MEM or mid-WRITE: the in-flight instruction is dropped, with no write or error pulse after release.

Decomposition:
- Shared package holds:
  - load-type encodings (LT_LW..LT_LBU);
  - wb_err codes (ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT);
  - FSM state encodings.
- One natural combinational sub-module, load_extract: (mem_rdata, load_type, addr_lo) → 32-bit result.
- FSM, counters and output registers remain in wb_stage.

Test Plan:
- Reset release, then ALU op rd=5, result 0x12345678 → one cycle later regwrite=1, Write_Reg_Num=5, Write_Data=0x12345678; retire_count=1.
- LB addr_lo=2, mem_rdata=0x11228344 after 3 cycles → WAIT_MEM for 3 cycles, in_ready=0; then Write_Data=0xFFFFFF83. Same stimulus with LBU → 0x00000083.
- LHU addr_lo=2 with mem_rdata=0xAAAA8001 → Write_Data=0x00008001. LH addr_lo=1 → wb_err=01, no regwrite, retire_count unchanged.
- ALU ops rd=0 and rd=7 back-to-back → rd=0 gives no regwrite pulse; rd=7 is written on the following cycle; retire_count advances by 2; in_ready stays 1 throughout.
- Load with no mem_rdata_valid, MEM_TIMEOUT=16 → wb_err=10 after 16 WAIT_MEM cycles, state IDLE, no write. A late mem_rdata_valid is ignored.
- Assert reset during WAIT_MEM → all outputs 0 immediately; after release, no regwrite and no wb_err pulse, in_ready=1.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: load types, error codes, FSM states.
package wb_stage_pkg;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WRITE    = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic [2:0] lt;
        logic [1:0] addr_lo;
    } ld_req_t;

    // Unknown load types behave as LW, so they need word alignment too.
    function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] addr_lo);
        case (lt)
            LT_LB, LT_LBU: return 1'b0;
            LT_LH, LT_LHU: return addr_lo[0];
            default:       return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/wb_stage_load_extract.sv
// Big-endian byte/halfword/word extraction with sign or zero extension.
module load_extract
    import wb_stage_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [3:0][7:0]  lanes;
    logic [1:0][15:0] halves;
    logic [7:0]       b;
    logic [15:0]      h;

    assign lanes  = mem_rdata;
    assign halves = mem_rdata;
    // Address lane 0 is the most significant byte, hence the reversed index.
    assign b = lanes[2'd3 - addr_lo];
    assign h = halves[~addr_lo[1]];

    always_comb begin
        data = mem_rdata;
        case (load_type)
            LT_LB:   data = {{24{b[7]}}, b};
            LT_LBU:  data = {24'd0, b};
            LT_LH:   data = {{16{h[15]}}, h};
            LT_LHU:  data = {16'd0, h};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts ALU results or loads, waits for load data, and
// drives a registered one-cycle register-file write with forwarding/error status.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_regwrite,
    input  logic             in_memtoreg,
    input  logic [2:0]       in_load_type,
    input  logic [31:0]      in_alu_result,
    input  logic             mem_rdata_valid,
    input  logic [31:0]      mem_rdata,
    output logic [4:0]       Write_Reg_Num,
    output logic [31:0]      Write_Data,
    output logic             regwrite,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [1:0]       wb_err,
    output logic [CNT_W-1:0] retire_count
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    wb_state_t   state;
    ld_req_t     cap;
    logic [TW-1:0] tcnt;
    logic [31:0] ld_data;
    logic        xfer;
    logic        in_we;

    load_extract u_extract (
        .mem_rdata (mem_rdata),
        .load_type (cap.lt),
        .addr_lo   (cap.addr_lo),
        .data      (ld_data)
    );

    assign in_ready = (state == S_IDLE) || (state == S_WRITE);
    assign xfer     = in_valid && in_ready;
    assign in_we    = in_regwrite && (in_rd != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            cap           <= '0;
            tcnt          <= '0;
            regwrite      <= 1'b0;
            Write_Reg_Num <= '0;
            Write_Data    <= '0;
            fwd_valid     <= 1'b0;
            fwd_rd        <= '0;
            wb_err        <= ERR_NONE;
            retire_count  <= '0;
        end else begin
            regwrite <= 1'b0;
            wb_err   <= ERR_NONE;
            case (state)
                S_IDLE, S_WRITE: begin
                    state     <= S_IDLE;
                    fwd_valid <= 1'b0;
                    if (xfer) begin
                        if (!in_memtoreg) begin
                            state         <= S_WRITE;
                            Write_Data    <= in_alu_result;
                            Write_Reg_Num <= in_rd;
                            regwrite      <= in_we;
                            retire_count  <= retire_count + CNT_W'(1);
                            fwd_valid     <= in_we;
                            if (in_we) fwd_rd <= in_rd;
                        end else if (is_misaligned(in_load_type, in_alu_result[1:0])) begin
                            wb_err <= ERR_MISALIGN;
                        end else begin
                            state       <= S_WAIT_MEM;
                            cap.rd      <= in_rd;
                            cap.we      <= in_we;
                            cap.lt      <= in_load_type;
                            cap.addr_lo <= in_alu_result[1:0];
                            tcnt        <= '0;
                            fwd_valid   <= in_we;
                            if (in_we) fwd_rd <= in_rd;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    // Data arriving on the last allowed cycle still wins over the timeout.
                    if (mem_rdata_valid) begin
                        state         <= S_WRITE;
                        Write_Data    <= ld_data;
                        Write_Reg_Num <= cap.rd;
                        regwrite      <= cap.we;
                        retire_count  <= retire_count + CNT_W'(1);
                    end else if (MEM_TIMEOUT != 0 && tcnt == TLAST) begin
                        state     <= S_IDLE;
                        wb_err    <= ERR_TIMEOUT;
                        fwd_valid <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
